// File: rtl/memory_access.sv
// MEM pipeline stage: EX/MEM register, branch resolution, and a req/ack data-memory port.
// Optional `MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES cycles without ack.
module memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] branch_or_not_address,
    input  logic        zero,
    input  logic [31:0] ALU_result,
    input  logic [4:0]  write_register,
    input  logic [31:0] read_data_2,
    input  logic        ctrl_memRead,
    input  logic        ctrl_memWrite,
    input  logic        ctrl_branch,
    input  logic        ctrl_regWrite,
    input  logic        ctrl_memToReg,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        valid_mem_wb,
    output logic [31:0] read_data_mem_wb,
    output logic [31:0] alu_result_mem_wb,
    output logic [4:0]  write_register_mem_wb,
    output logic        ctrl_regWrite_mem_wb,
    output logic        ctrl_memToReg_mem_wb,
    output logic        mem_error
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e      state_q, state_d;

    // EX/MEM register
    logic [31:0] ex_alu_q, ex_alu_d;
    logic [31:0] ex_wdata_q, ex_wdata_d;
    logic [4:0]  ex_wr_q, ex_wr_d;
    logic        ex_mem_read_q, ex_mem_read_d;
    logic        ex_mem_write_q, ex_mem_write_d;
    logic        ex_reg_write_q, ex_reg_write_d;
    logic        ex_mem_to_reg_q, ex_mem_to_reg_d;
    logic [31:0] bt_q, bt_d;
    logic        pc_src_q, pc_src_d;

    // MEM/WB register
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [4:0]  wb_wr_q, wb_wr_d;
    logic        wb_rw_q, wb_rw_d;
    logic        wb_m2r_q, wb_m2r_d;

    logic        is_mem;
    logic        bad_op;

    assign is_mem = ctrl_memRead | ctrl_memWrite;
    assign bad_op = (ctrl_memRead & ctrl_memWrite) | (is_mem & (ALU_result[1:0] != 2'b00));

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout;

    // cnt_q counts ACCESS cycles already spent without ack; this one would be the limit.
    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d         = state_q;
        ex_alu_d        = ex_alu_q;
        ex_wdata_d      = ex_wdata_q;
        ex_wr_d         = ex_wr_q;
        ex_mem_read_d   = ex_mem_read_q;
        ex_mem_write_d  = ex_mem_write_q;
        ex_reg_write_d  = ex_reg_write_q;
        ex_mem_to_reg_d = ex_mem_to_reg_q;
        bt_d            = bt_q;
        pc_src_d        = 1'b0;
        valid_d         = 1'b0;
        err_d           = 1'b0;
        wb_rdata_d      = wb_rdata_q;
        wb_alu_d        = wb_alu_q;
        wb_wr_d         = wb_wr_q;
        wb_rw_d         = wb_rw_q;
        wb_m2r_d        = wb_m2r_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d           = cnt_q;
`endif

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    ex_alu_d        = ALU_result;
                    ex_wdata_d      = read_data_2;
                    ex_wr_d         = write_register;
                    ex_mem_read_d   = ctrl_memRead;
                    ex_mem_write_d  = ctrl_memWrite;
                    ex_reg_write_d  = ctrl_regWrite;
                    ex_mem_to_reg_d = ctrl_memToReg;
                    bt_d            = branch_or_not_address;
                    pc_src_d        = ctrl_branch & zero;
                    if (bad_op) begin
                        valid_d    = 1'b1;
                        err_d      = 1'b1;
                        wb_rdata_d = '0;
                        wb_alu_d   = ALU_result;
                        wb_wr_d    = write_register;
                        wb_rw_d    = 1'b0;
                        wb_m2r_d   = 1'b0;
                    end else if (is_mem) begin
                        state_d = StAccess;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        valid_d    = 1'b1;
                        wb_rdata_d = '0;
                        wb_alu_d   = ALU_result;
                        wb_wr_d    = write_register;
                        wb_rw_d    = ctrl_regWrite;
                        wb_m2r_d   = ctrl_memToReg;
                    end
                end
            end
            StAccess: begin
                if (dmem_ack) begin
                    state_d    = StIdle;
                    valid_d    = 1'b1;
                    wb_rdata_d = ex_mem_read_q ? dmem_rdata : 32'h0;
                    wb_alu_d   = ex_alu_q;
                    wb_wr_d    = ex_wr_q;
                    wb_rw_d    = ex_reg_write_q;
                    wb_m2r_d   = ex_mem_to_reg_q;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    state_d    = StIdle;
                    valid_d    = 1'b1;
                    err_d      = 1'b1;
                    wb_rdata_d = '0;
                    wb_alu_d   = ex_alu_q;
                    wb_wr_d    = ex_wr_q;
                    wb_rw_d    = 1'b0;
                    wb_m2r_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            ex_alu_q        <= '0;
            ex_wdata_q      <= '0;
            ex_wr_q         <= '0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
            bt_q            <= '0;
            pc_src_q        <= 1'b0;
            valid_q         <= 1'b0;
            err_q           <= 1'b0;
            wb_rdata_q      <= '0;
            wb_alu_q        <= '0;
            wb_wr_q         <= '0;
            wb_rw_q         <= 1'b0;
            wb_m2r_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            ex_alu_q        <= ex_alu_d;
            ex_wdata_q      <= ex_wdata_d;
            ex_wr_q         <= ex_wr_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_to_reg_q <= ex_mem_to_reg_d;
            bt_q            <= bt_d;
            pc_src_q        <= pc_src_d;
            valid_q         <= valid_d;
            err_q           <= err_d;
            wb_rdata_q      <= wb_rdata_d;
            wb_alu_q        <= wb_alu_d;
            wb_wr_q         <= wb_wr_d;
            wb_rw_q         <= wb_rw_d;
            wb_m2r_q        <= wb_m2r_d;
        end
    end

    // Request and stall follow state directly so an async reset drops them at once.
    assign stall                 = (state_q == StAccess);
    assign dmem_req              = (state_q == StAccess);
    assign dmem_we               = ex_mem_write_q;
    assign dmem_addr             = ex_alu_q;
    assign dmem_wdata            = ex_wdata_q;
    assign pc_src                = pc_src_q;
    assign branch_target         = bt_q;
    assign valid_mem_wb          = valid_q;
    assign mem_error             = err_q;
    assign read_data_mem_wb      = wb_rdata_q;
    assign alu_result_mem_wb     = wb_alu_q;
    assign write_register_mem_wb = wb_wr_q;
    assign ctrl_regWrite_mem_wb  = wb_rw_q;
    assign ctrl_memToReg_mem_wb  = wb_m2r_q;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_memory_access;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] branch_or_not_address = '0;
    logic        zero = 1'b0;
    logic [31:0] ALU_result = '0;
    logic [4:0]  write_register = '0;
    logic [31:0] read_data_2 = '0;
    logic        ctrl_memRead = 1'b0, ctrl_memWrite = 1'b0, ctrl_branch = 1'b0;
    logic        ctrl_regWrite = 1'b0, ctrl_memToReg = 1'b0;
    logic        stall, pc_src, dmem_req, dmem_we;
    logic [31:0] branch_target, dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        valid_mem_wb, ctrl_regWrite_mem_wb, ctrl_memToReg_mem_wb, mem_error;
    logic [31:0] read_data_mem_wb, alu_result_mem_wb;
    logic [4:0]  write_register_mem_wb;

    memory_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .branch_or_not_address(branch_or_not_address), .zero(zero),
        .ALU_result(ALU_result), .write_register(write_register), .read_data_2(read_data_2),
        .ctrl_memRead(ctrl_memRead), .ctrl_memWrite(ctrl_memWrite), .ctrl_branch(ctrl_branch),
        .ctrl_regWrite(ctrl_regWrite), .ctrl_memToReg(ctrl_memToReg),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .valid_mem_wb(valid_mem_wb), .read_data_mem_wb(read_data_mem_wb),
        .alu_result_mem_wb(alu_result_mem_wb), .write_register_mem_wb(write_register_mem_wb),
        .ctrl_regWrite_mem_wb(ctrl_regWrite_mem_wb), .ctrl_memToReg_mem_wb(ctrl_memToReg_mem_wb),
        .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model: the instruction in flight and the outputs it must produce.
    bit          busy;
    int          waited;
    logic [31:0] c_alu, c_wd;
    logic [4:0]  c_wr;
    logic        c_rd, c_rw, c_m2r;
    logic [31:0] m_bt, m_rdata, m_alu, m_addr, m_wdata;
    logic [4:0]  m_wr;
    logic        m_pc, m_valid, m_err, m_rw, m_m2r, m_we;

    task automatic retire(input logic [31:0] rdata, input logic err);
        m_valid = 1'b1;
        m_err   = err;
        m_rdata = rdata;
        m_alu   = c_alu;
        m_wr    = c_wr;
        m_rw    = err ? 1'b0 : c_rw;
        m_m2r   = err ? 1'b0 : c_m2r;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                busy = 0; waited = 0;
                m_bt = 0; m_rdata = 0; m_alu = 0; m_addr = 0; m_wdata = 0; m_wr = 0;
                m_pc = 0; m_valid = 0; m_err = 0; m_rw = 0; m_m2r = 0; m_we = 0;
            end else begin
                m_pc = 0; m_valid = 0; m_err = 0;
                if (busy) begin
                    if (dmem_ack) begin
                        busy = 0;
                        retire(c_rd ? dmem_rdata : 32'h0, 1'b0);
                    end
`ifdef MEM_TIMEOUT_EN
                    else begin
                        waited++;
                        if (waited == TO) begin
                            busy = 0;
                            retire(32'h0, 1'b1);
                        end
                    end
`endif
                end else if (in_valid) begin
                    m_bt  = branch_or_not_address;
                    m_pc  = ctrl_branch & zero;
                    c_alu = ALU_result; c_wd = read_data_2; c_wr = write_register;
                    c_rd  = ctrl_memRead; c_rw = ctrl_regWrite; c_m2r = ctrl_memToReg;
                    if ((ctrl_memRead && ctrl_memWrite) ||
                        ((ctrl_memRead || ctrl_memWrite) && (ALU_result % 4 != 0))) begin
                        retire(32'h0, 1'b1);
                    end else if (ctrl_memRead || ctrl_memWrite) begin
                        busy = 1; waited = 0;
                        m_we = ctrl_memWrite; m_addr = ALU_result; m_wdata = read_data_2;
                    end else begin
                        retire(32'h0, 1'b0);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("stall", stall, busy);
                check("dmem_req", dmem_req, busy);
                check("pc_src", pc_src, m_pc);
                check("branch_target", branch_target, m_bt);
                check("valid_mem_wb", valid_mem_wb, m_valid);
                check("mem_error", mem_error, m_err);
                check("read_data_mem_wb", read_data_mem_wb, m_rdata);
                check("alu_result_mem_wb", alu_result_mem_wb, m_alu);
                check("write_register_mem_wb", {27'h0, write_register_mem_wb}, {27'h0, m_wr});
                check("regWrite_mem_wb", ctrl_regWrite_mem_wb, m_rw);
                check("memToReg_mem_wb", ctrl_memToReg_mem_wb, m_m2r);
                if (busy) begin
                    check("dmem_we", dmem_we, m_we);
                    check("dmem_addr", dmem_addr, m_addr);
                    check("dmem_wdata", dmem_wdata, m_wdata);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] alu, input logic [4:0] wr, input logic [31:0] wd,
                         input logic rd, input logic wt, input logic br, input logic z,
                         input logic [31:0] bta, input logic rw, input logic m2r);
        in_valid = 1'b1; ALU_result = alu; write_register = wr; read_data_2 = wd;
        ctrl_memRead = rd; ctrl_memWrite = wt; ctrl_branch = br; zero = z;
        branch_or_not_address = bta; ctrl_regWrite = rw; ctrl_memToReg = m2r;
    endtask

    task automatic quiet();
        in_valid = 1'b0; ctrl_memRead = 1'b0; ctrl_memWrite = 1'b0; ctrl_branch = 1'b0;
    endtask

    initial begin
        #1;
        check("reset valid", valid_mem_wb, 1'b0);
        check("reset req", dmem_req, 1'b0);
        check("reset stall", stall, 1'b0);
        check("reset alu_wb", alu_result_mem_wb, 32'h0);
        @(negedge clk); reset = 1'b1;
        chk_en = 1'b1;

        // Non-memory op
        @(negedge clk); issue(32'h10, 5'd5, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0);
        @(negedge clk); quiet();
        check("nm valid", valid_mem_wb, 1'b1);
        check("nm alu", alu_result_mem_wb, 32'h10);
        check("nm wr", {27'h0, write_register_mem_wb}, 32'd5);
        check("nm stall", stall, 1'b0);
        check("nm req", dmem_req, 1'b0);
        @(negedge clk);
        check("nm valid pulse", valid_mem_wb, 1'b0);

        // Load with 3-cycle ack delay
        issue(32'h100, 5'd7, 32'h0, 1, 0, 0, 0, 32'h0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); quiet();
            check("ld req", dmem_req, 1'b1);
            check("ld addr", dmem_addr, 32'h100);
            check("ld we", dmem_we, 1'b0);
            if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; end
        end
        @(negedge clk); dmem_ack = 1'b0;
        check("ld req off", dmem_req, 1'b0);
        check("ld valid", valid_mem_wb, 1'b1);
        check("ld rdata", read_data_mem_wb, 32'hDEADBEEF);

        // Store with immediate ack
        @(negedge clk); issue(32'h20, 5'd0, 32'h12345678, 0, 1, 0, 0, 32'h0, 0, 0);
        @(negedge clk); quiet();
        check("st we", dmem_we, 1'b1);
        check("st wdata", dmem_wdata, 32'h12345678);
        dmem_ack = 1'b1;
        @(negedge clk); dmem_ack = 1'b0;
        check("st valid", valid_mem_wb, 1'b1);
        check("st regWrite", ctrl_regWrite_mem_wb, 1'b0);
        check("st rdata", read_data_mem_wb, 32'h0);

        // Branch taken, then not taken
        @(negedge clk); issue(32'h0, 5'd0, 32'h0, 0, 0, 1, 1, 32'h40, 0, 0);
        @(negedge clk); issue(32'h0, 5'd0, 32'h0, 0, 0, 1, 0, 32'h40, 0, 0);
        check("br pc_src", pc_src, 1'b1);
        check("br target", branch_target, 32'h40);
        @(negedge clk); quiet();
        check("br nt pc_src", pc_src, 1'b0);

        // Misaligned load
        @(negedge clk); issue(32'h102, 5'd3, 32'h0, 1, 0, 0, 0, 32'h0, 1, 1);
        @(negedge clk); quiet();
        check("mis req", dmem_req, 1'b0);
        check("mis err", mem_error, 1'b1);
        check("mis valid", valid_mem_wb, 1'b1);
        check("mis regWrite", ctrl_regWrite_mem_wb, 1'b0);
        @(negedge clk);
        check("mis err pulse", mem_error, 1'b0);

`ifdef MEM_TIMEOUT_EN
        issue(32'h200, 5'd9, 32'h0, 1, 0, 0, 0, 32'h0, 1, 1);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk); quiet();
            check("to req", dmem_req, 1'b1);
        end
        @(negedge clk);
        check("to req off", dmem_req, 1'b0);
        check("to err", mem_error, 1'b1);
        check("to valid", valid_mem_wb, 1'b1);
        check("to regWrite", ctrl_regWrite_mem_wb, 1'b0);
`endif

        // Reset mid-access, then a stray ack
        @(negedge clk); issue(32'h300, 5'd4, 32'h0, 1, 0, 1, 1, 32'h80, 1, 1);
        @(negedge clk); quiet();
        check("rst pre req", dmem_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rst req", dmem_req, 1'b0);
        check("rst stall", stall, 1'b0);
        check("rst target", branch_target, 32'h0);
        check("rst alu_wb", alu_result_mem_wb, 32'h0);
        @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); dmem_ack = 1'b0;
        check("stray ack valid", valid_mem_wb, 1'b0);
        check("stray ack req", dmem_req, 1'b0);

        // Random traffic; DUT's request only chooses when the memory may answer.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            dmem_ack   = ($urandom_range(0, 2) == 0);
            dmem_rdata = $urandom;
            in_valid   = $urandom_range(0, 1);
            branch_or_not_address = $urandom;
            zero = $urandom_range(0, 1);
            ctrl_branch = $urandom_range(0, 1);
            write_register = 5'($urandom);
            read_data_2 = $urandom;
            ctrl_regWrite = $urandom_range(0, 1);
            ctrl_memToReg = $urandom_range(0, 1);
            ALU_result = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(0, 4))
                0: begin ctrl_memRead = 0; ctrl_memWrite = 0; ALU_result = $urandom; end
                1: begin ctrl_memRead = 1; ctrl_memWrite = 0; end
                2: begin ctrl_memRead = 0; ctrl_memWrite = 1; end
                3: begin
                    ctrl_memRead = 1; ctrl_memWrite = 0;
                    ALU_result = ALU_result | 32'($urandom_range(1, 3));
                end
                default: begin ctrl_memRead = 1; ctrl_memWrite = 1; end
            endcase
        end
        @(negedge clk); quiet(); dmem_ack = 1'b1;
        @(negedge clk); dmem_ack = 1'b0;
        @(negedge clk); chk_en = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
